espirometro_control: RTL and testbench
======================================

ESPIROMETRO_CONTROL -- requirements
Module: espirometro_control

Interface
REQ-001 SHALL have parameter CE_DIV, default 50000, meaning Clk cycles per oCE tick (>=2).
REQ-002 SHALL have parameter NUM_SAMPLES, default 200, meaning flow samples per measurement (1..65535).
REQ-003 SHALL have parameter TIMEOUT_TICKS, default 1000, meaning oCE ticks allowed between samples in MIDE.
REQ-004 SHALL have port Clk  input  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port Rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port iStart  input  1  start measurement / acknowledge result.
REQ-007 SHALL have port iAbort  input  1  abandon measurement.
REQ-008 SHALL have port iSampleValid  input  1  one-cycle flow sample strobe.
REQ-009 SHALL have port ivFlow  input  8  unsigned flow sample.
REQ-010 SHALL have port oCE  output  1  one-cycle clock-enable tick for the spirometer datapath (peso register and others).
REQ-011 SHALL have port ovStateMachine  output  2  current state code.
REQ-012 SHALL have port ovVolume  output  16  volume of last completed measurement.
REQ-013 SHALL have port oDone  output  1  high while in FIN.
REQ-014 SHALL have port oTimeout  output  1  high in FIN when entered by timeout.

Function
REQ-015 SHALL implement states PESO=0, MIDE=1, CALC=2, FIN=3, encoded directly on ovStateMachine from a register (no combinational path from inputs).
REQ-016 SHALL generate oCE from a free-running counter 0..CE_DIV-1, high for one cycle when counter equals CE_DIV-1, independent of state.
REQ-017 PESO: iStart=1 -> MIDE next cycle; accumulator, sample count and tick-timeout counter cleared on that transition.
REQ-018 MIDE: each iSampleValid adds ivFlow zero-extended to a 16-bit accumulator, saturating at 0xFFFF (no wrap), increments sample count and clears timeout counter.
REQ-019 MIDE: when the accepted sample makes count equal NUM_SAMPLES -> CALC next cycle.
REQ-020 MIDE: timeout counter increments on each oCE without sample; reaching TIMEOUT_TICKS -> FIN with oTimeout=1, ovVolume unchanged.
REQ-021 Sample and timeout in same cycle: sample wins; timeout counter cleared.
REQ-022 CALC: one cycle; ovVolume loaded from accumulator; -> FIN with oTimeout=0.
REQ-023 FIN: oDone=1; iStart=1 -> PESO next cycle (acknowledge only, no new measurement that cycle); oTimeout cleared on leaving FIN.
REQ-024 iAbort=1 in MIDE or CALC -> PESO next cycle, accumulator cleared, ovVolume unchanged; iAbort has priority over iStart and iSampleValid; ignored in PESO and FIN.
REQ-025 iSampleValid outside MIDE SHALL be ignored.

Reset
REQ-026 Rst=1 SHALL on the next Clk edge force state PESO, oCE=0, divider=0, accumulator=0, sample count=0, timeout counter=0, ovVolume=0, oDone=0, oTimeout=0, overriding all inputs, including mid-measurement.

Configuration
REQ-027 Macro ESPIROMETRO_TIMEOUT_EN defined: REQ-020/021 timeout logic and oTimeout behaviour compiled in.
REQ-028 Macro ESPIROMETRO_TIMEOUT_EN undefined: no timeout counter; MIDE exits only by NUM_SAMPLES or iAbort; oTimeout tied 0; port list unchanged.

Verification (CE_DIV=4, NUM_SAMPLES=4, TIMEOUT_TICKS=3)
REQ-029 Normal run: iStart pulse, samples 10,20,30,40 -> states 0,1,2,3; ovVolume=100, oDone=1, oTimeout=0; iStart in FIN -> state 0, ovVolume stays 100.
REQ-030 Saturation: four samples of 0xFF with accumulator preloaded by prior runs irrelevant; NUM_SAMPLES=300 variant, 300x0xFF -> ovVolume=0xFFFF, not wrapped.
REQ-031 Timeout (macro on): iStart, no samples -> FIN after 3 oCE ticks, oTimeout=1, ovVolume unchanged; macro off -> stays MIDE indefinitely.
REQ-032 Priority: iAbort with iSampleValid in MIDE after 2 samples -> PESO, later full run of 1,1,1,1 gives ovVolume=4.
REQ-033 Reset mid-MIDE after 2 samples -> all outputs 0, state PESO next edge; oCE period 4 cycles from reset, first pulse 4th cycle after reset release.

Source files
------------

// File: rtl/espirometro_control.sv
// espirometro_control: spirometer measurement sequencer with clock-enable divider
// Ports: Clk/Rst (sync, active-high); iStart start/acknowledge; iAbort abandon;
//        iSampleValid/ivFlow flow samples; oCE datapath tick; ovStateMachine state;
//        ovVolume last volume; oDone in FIN; oTimeout FIN reached by timeout.
// Optional: define ESPIROMETRO_TIMEOUT_EN to compile in the sample timeout.
module espirometro_control #(
    parameter int unsigned CE_DIV        = 50000,
    parameter int unsigned NUM_SAMPLES   = 200,
    parameter int unsigned TIMEOUT_TICKS = 1000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        iStart,
    input  logic        iAbort,
    input  logic        iSampleValid,
    input  logic [7:0]  ivFlow,
    output logic        oCE,
    output logic [1:0]  ovStateMachine,
    output logic [15:0] ovVolume,
    output logic        oDone,
    output logic        oTimeout
);
    localparam int unsigned CW = $clog2(CE_DIV);

    typedef enum logic [1:0] {PESO = 2'd0, MIDE = 2'd1, CALC = 2'd2, FIN = 2'd3} tState;

    tState       state, nextState;
    logic [CW-1:0] ceCnt;
    logic [15:0] acc, nextAcc;
    logic [15:0] sampleCnt, nextCnt;
    logic [15:0] volume, nextVolume;
    logic        timeoutFlag, nextTimeout;
    logic [16:0] sum, cntInc;

    if (TIMEOUT_TICKS < 1) begin : gBadTimeout
        $error("TIMEOUT_TICKS must be at least 1");
    end

`ifdef ESPIROMETRO_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);
    logic [TW-1:0] toCnt, nextTo, toInc;
    assign toInc = toCnt + 1'b1;
`endif

    assign oCE            = (ceCnt == CW'(CE_DIV - 1));
    assign ovStateMachine = state;
    assign ovVolume       = volume;
    assign oDone          = (state == FIN);
    assign oTimeout       = timeoutFlag;
    assign sum            = {1'b0, acc} + {9'd0, ivFlow};
    assign cntInc         = {1'b0, sampleCnt} + 17'd1;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= PESO;
            ceCnt       <= '0;
            acc         <= '0;
            sampleCnt   <= '0;
            volume      <= '0;
            timeoutFlag <= 1'b0;
`ifdef ESPIROMETRO_TIMEOUT_EN
            toCnt       <= '0;
`endif
        end else begin
            state       <= nextState;
            ceCnt       <= oCE ? '0 : ceCnt + 1'b1;
            acc         <= nextAcc;
            sampleCnt   <= nextCnt;
            volume      <= nextVolume;
            timeoutFlag <= nextTimeout;
`ifdef ESPIROMETRO_TIMEOUT_EN
            toCnt       <= nextTo;
`endif
        end
    end

    always_comb begin
        nextState   = state;
        nextAcc     = acc;
        nextCnt     = sampleCnt;
        nextVolume  = volume;
        nextTimeout = timeoutFlag;
`ifdef ESPIROMETRO_TIMEOUT_EN
        nextTo      = toCnt;
`endif
        case (state)
            PESO: if (iStart) begin
                nextState = MIDE;
                nextAcc   = '0;
                nextCnt   = '0;
`ifdef ESPIROMETRO_TIMEOUT_EN
                nextTo    = '0;
`endif
            end
            MIDE: if (iAbort) begin
                nextState = PESO;
                nextAcc   = '0;
            end else if (iSampleValid) begin
                // saturate instead of wrapping so overflow reads as full scale
                nextAcc = sum[16] ? 16'hFFFF : sum[15:0];
                nextCnt = cntInc[15:0];
`ifdef ESPIROMETRO_TIMEOUT_EN
                nextTo  = '0;
`endif
                if (cntInc == 17'(NUM_SAMPLES)) nextState = CALC;
`ifdef ESPIROMETRO_TIMEOUT_EN
            end else if (oCE) begin
                nextTo = toInc;
                if (toInc == TW'(TIMEOUT_TICKS)) begin
                    nextState   = FIN;
                    nextTimeout = 1'b1;
                end
`endif
            end
            CALC: if (iAbort) begin
                nextState = PESO;
                nextAcc   = '0;
            end else begin
                nextState   = FIN;
                nextVolume  = acc;
                nextTimeout = 1'b0;
            end
            FIN: if (iStart) begin
                nextState   = PESO;
                nextTimeout = 1'b0;
            end
            default: nextState = PESO;
        endcase
    end
endmodule

// File: tb/tb_espirometro_control.sv
// tb_espirometro_control: directed self-checking bench for espirometro_control
module tb_espirometro_control;
    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        iStart = 1'b0, iAbort = 1'b0, iSampleValid = 1'b0;
    logic [7:0]  ivFlow = 8'd0;
    logic        oCE, oDone, oTimeout;
    logic [1:0]  ovStateMachine;
    logic [15:0] ovVolume;

    logic        iStart2 = 1'b0, iSampleValid2 = 1'b0;
    logic [7:0]  ivFlow2 = 8'd0;
    logic        oCE2, oDone2, oTimeout2;
    logic [1:0]  ovStateMachine2;
    logic [15:0] ovVolume2;

    int vectors = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    espirometro_control #(.CE_DIV(4), .NUM_SAMPLES(4), .TIMEOUT_TICKS(3)) dut (
        .Clk(Clk), .Rst(Rst), .iStart(iStart), .iAbort(iAbort),
        .iSampleValid(iSampleValid), .ivFlow(ivFlow), .oCE(oCE),
        .ovStateMachine(ovStateMachine), .ovVolume(ovVolume),
        .oDone(oDone), .oTimeout(oTimeout)
    );

    espirometro_control #(.CE_DIV(4), .NUM_SAMPLES(300), .TIMEOUT_TICKS(3)) dut300 (
        .Clk(Clk), .Rst(Rst), .iStart(iStart2), .iAbort(1'b0),
        .iSampleValid(iSampleValid2), .ivFlow(ivFlow2), .oCE(oCE2),
        .ovStateMachine(ovStateMachine2), .ovVolume(ovVolume2),
        .oDone(oDone2), .oTimeout(oTimeout2)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic sample(input logic [7:0] v);
        iSampleValid = 1'b1;
        ivFlow = v;
        tick();
        iSampleValid = 1'b0;
        ivFlow = 8'd0;
    endtask

    task automatic startRun();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        chk("start->MIDE", 32'(ovStateMachine), 32'd1);
    endtask

    task automatic fullRun(input logic [7:0] a, b, c, d, input logic [15:0] vol);
        startRun();
        sample(a);
        sample(b);
        sample(c);
        chk("pre-last MIDE", 32'(ovStateMachine), 32'd1);
        sample(d);
        chk("CALC", 32'(ovStateMachine), 32'd2);
        chk("CALC not done", 32'(oDone), 32'd0);
        tick();
        chk("FIN", 32'(ovStateMachine), 32'd3);
        chk("FIN volume", 32'(ovVolume), 32'(vol));
        chk("FIN done", 32'(oDone), 32'd1);
        chk("FIN no timeout", 32'(oTimeout), 32'd0);
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        chk("ack->PESO", 32'(ovStateMachine), 32'd0);
        chk("ack keeps volume", 32'(ovVolume), 32'(vol));
        chk("ack clears done", 32'(oDone), 32'd0);
    endtask

    task automatic ceAfterReset();
        for (int i = 0; i < 8; i++) begin
            chk("oCE cadence", 32'(oCE), 32'((i % 4) == 3));
            tick();
        end
    endtask

    initial begin
        int ceSeen;
        bit reached;
        tick();
        tick();
        chk("rst state", 32'(ovStateMachine), 32'd0);
        chk("rst volume", 32'(ovVolume), 32'd0);
        chk("rst done", 32'(oDone), 32'd0);
        chk("rst timeout", 32'(oTimeout), 32'd0);
        chk("rst oCE", 32'(oCE), 32'd0);
        Rst = 1'b0;
        ceAfterReset();

        fullRun(8'd10, 8'd20, 8'd30, 8'd40, 16'd100);

        iSampleValid = 1'b1;
        ivFlow = 8'd50;
        iAbort = 1'b1;
        tick();
        iSampleValid = 1'b0;
        iAbort = 1'b0;
        chk("PESO ignores sample/abort", 32'(ovStateMachine), 32'd0);

        fullRun(8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'h03FC);

        startRun();
        sample(8'd5);
        sample(8'd5);
        iAbort = 1'b1;
        iSampleValid = 1'b1;
        ivFlow = 8'd9;
        iStart = 1'b1;
        tick();
        iAbort = 1'b0;
        iSampleValid = 1'b0;
        iStart = 1'b0;
        chk("abort MIDE->PESO", 32'(ovStateMachine), 32'd0);
        chk("abort keeps volume", 32'(ovVolume), 32'h03FC);

        fullRun(8'd1, 8'd1, 8'd1, 8'd1, 16'd4);

        startRun();
        sample(8'd7);
        sample(8'd7);
        sample(8'd7);
        sample(8'd7);
        chk("CALC before abort", 32'(ovStateMachine), 32'd2);
        iAbort = 1'b1;
        tick();
        iAbort = 1'b0;
        chk("abort CALC->PESO", 32'(ovStateMachine), 32'd0);
        chk("abort CALC volume", 32'(ovVolume), 32'd4);

        startRun();
        ceSeen = 0;
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            if (ovStateMachine == 2'd3) reached = 1'b1;
            else begin
                if (oCE) ceSeen++;
                tick();
            end
        end
`ifdef ESPIROMETRO_TIMEOUT_EN
        chk("timeout reached FIN", 32'(reached), 32'd1);
        chk("timeout tick count", 32'(ceSeen), 32'd3);
        chk("timeout flag", 32'(oTimeout), 32'd1);
        chk("timeout done", 32'(oDone), 32'd1);
        chk("timeout volume", 32'(ovVolume), 32'd4);
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        chk("timeout ack state", 32'(ovStateMachine), 32'd0);
        chk("timeout flag cleared", 32'(oTimeout), 32'd0);
`else
        chk("no timeout stays MIDE", 32'(ovStateMachine), 32'd1);
        chk("no timeout flag", 32'(oTimeout), 32'd0);
        iAbort = 1'b1;
        tick();
        iAbort = 1'b0;
        chk("no timeout abort", 32'(ovStateMachine), 32'd0);
`endif

        startRun();
        sample(8'd2);
        sample(8'd2);
        Rst = 1'b1;
        iSampleValid = 1'b1;
        ivFlow = 8'd2;
        tick();
        iSampleValid = 1'b0;
        chk("midrst state", 32'(ovStateMachine), 32'd0);
        chk("midrst volume", 32'(ovVolume), 32'd0);
        chk("midrst done", 32'(oDone), 32'd0);
        chk("midrst timeout", 32'(oTimeout), 32'd0);
        chk("midrst oCE", 32'(oCE), 32'd0);
        Rst = 1'b0;
        ceAfterReset();

        iStart2 = 1'b1;
        tick();
        iStart2 = 1'b0;
        chk("sat300 MIDE", 32'(ovStateMachine2), 32'd1);
        for (int i = 0; i < 300; i++) begin
            iSampleValid2 = 1'b1;
            ivFlow2 = 8'hFF;
            tick();
        end
        iSampleValid2 = 1'b0;
        chk("sat300 CALC", 32'(ovStateMachine2), 32'd2);
        tick();
        chk("sat300 FIN", 32'(ovStateMachine2), 32'd3);
        chk("sat300 volume", 32'(ovVolume2), 32'h0000FFFF);
        chk("sat300 done", 32'(oDone2), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
